// File: rtl/int2float_pkg.sv
// Shared widths and FSM state type for the int2float converter scheduler.
package int2float_pkg;

  localparam int unsigned INT_W      = 11;
  localparam int unsigned FLT_W      = 7;
  localparam int unsigned DONE_CNT_W = 16;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request strictly after ptr, modulo N.
module rr_arbiter #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant_onehot,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  // ptr + k spans up to 2N-1, so one extra bit avoids wrap before the modulo fold
  logic [IDW:0] cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    cand         = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (IDW+1)'(ptr) + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (en && !any && req[cand[IDW-1:0]]) begin
        grant_onehot[cand[IDW-1:0]] = 1'b1;
        grant_idx                   = cand[IDW-1:0];
        any                         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int2float_sched.sv
// Time-shares one external int2float converter among N requesters with round-robin
// arbitration, a programmable conversion window and a valid/ready result port.
module int2float_sched
  import int2float_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned CONV_LAT = 1,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  input  logic [N*INT_W-1:0]    req_data,
  output logic [N-1:0]          req_ready,
  output logic [INT_W-1:0]      conv_x,
  input  logic [FLT_W-1:0]      conv_y,
  output logic                  out_valid,
  output logic [FLT_W-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [DONE_CNT_W-1:0] done_cnt
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("int2float_sched: N must be within 2..16");
  end
  if (CONV_LAT < 1 || CONV_LAT > 15) begin : g_bad_lat
    $error("int2float_sched: CONV_LAT must be within 1..15");
  end
  if (IDW != $clog2(N)) begin : g_bad_idw
    $error("int2float_sched: IDW must equal clog2(N)");
  end

  state_e                state_q, state_d;
  logic [INT_W-1:0]      x_q, x_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [FLT_W-1:0]      out_data_q, out_data_d;
  logic [IDW-1:0]        out_id_q, out_id_d;
  logic                  out_valid_q, out_valid_d;
  logic [DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic                  busy_q;

  logic                  arb_en;
  logic [N-1:0]          grant_oh;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_any;
  logic [INT_W-1:0]      grant_x;

  // Arbitrate only when the converter is free; held off entirely while in reset
  assign arb_en = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req          (req_valid),
    .ptr          (ptr_q),
    .en           (arb_en),
    .grant_onehot (grant_oh),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    grant_x = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_x = req_data[i*INT_W +: INT_W];
      end
    end
  end

  // Next-state: conversion window countdown, result capture, handshake and regrant
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    done_cnt_d  = done_cnt_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          out_data_d  = conv_y;
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (done_cnt_q != '1) begin
            done_cnt_d = done_cnt_q + DONE_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_any) begin
      x_d     = grant_x;
      id_d    = grant_idx;
      ptr_d   = grant_idx;
      cnt_d   = LAT_W'(CONV_LAT - 1);
      state_d = WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      id_q        <= '0;
      ptr_q       <= IDW'(N - 1);
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      done_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      done_cnt_q  <= done_cnt_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ready = grant_oh;
  assign conv_x    = x_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_int2float_sched.sv
// Scoreboard bench for int2float_sched: one DUT at CONV_LAT=1, one at CONV_LAT=3.
`timescale 1ns/1ps
module tb_int2float_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [43:0] req_data;
  logic [10:0] conv_x;
  logic [6:0]  conv_y, out_data;
  logic        out_valid, out_ready, busy;
  logic [1:0]  out_id;
  logic [15:0] done_cnt;

  logic [3:0]  req_valid3, req_ready3;
  logic [43:0] req_data3;
  logic [10:0] conv_x3;
  logic [6:0]  conv_y3, out_data3;
  logic        out_valid3, out_ready3, busy3, stub_en3;
  logic [1:0]  out_id3;
  logic [15:0] done_cnt3;

  assign conv_y  = conv_x[6:0] ^ 7'h55;
  assign conv_y3 = stub_en3 ? (conv_x3[6:0] ^ 7'h55) : 7'h00;

  int_dummy_guard u_guard ();

  int2float_sched #(.N(4), .CONV_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .conv_x(conv_x), .conv_y(conv_y), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready), .busy(busy),
    .done_cnt(done_cnt)
  );

  int2float_sched #(.N(4), .CONV_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .conv_x(conv_x3), .conv_y(conv_y3), .out_valid(out_valid3),
    .out_data(out_data3), .out_id(out_id3), .out_ready(out_ready3), .busy(busy3),
    .done_cnt(done_cnt3)
  );

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb_q[$];

  function automatic logic [6:0] model(input logic [10:0] x);
    return x[6:0] ^ 7'h55;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_data = {4{11'h7FF}}; out_ready = 1'b1;
    req_valid3 = 4'hF; req_data3 = '0; out_ready3 = 1'b1; stub_en3 = 1'b0;
    #12;
    checks++;
    if ({req_ready, conv_x, out_valid, out_data, out_id, busy, done_cnt} !== 42'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b x=%h v=%b d=%h id=%0d busy=%b cnt=%h exp all zero",
               req_ready, conv_x, out_valid, out_data, out_id, busy, done_cnt);
    end
    checks++;
    if ({req_ready3, out_valid3, busy3} !== 6'd0) begin
      failures++;
      $display("FAIL reset_state3 got rdy=%b v=%b busy=%b exp zero", req_ready3, out_valid3, busy3);
    end
    @(negedge clk); rst_n = 1'b1; req_valid = '0; req_valid3 = '0;
  endtask

  task automatic test_single();
    logic [8:0] e;
    @(negedge clk); req_valid = 4'b0001; req_data[10:0] = 11'h07F; #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    sb_q.push_back({2'd0, 7'h2A});
    @(negedge clk); req_valid = '0; #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || conv_x !== 11'h07F) begin
      failures++; $display("FAIL single_wait got v=%b busy=%b x=%h exp v=0 busy=1 x=07f", out_valid, busy, conv_x);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL single_latency got out_valid=%b exp=1", out_valid);
    end
    if (out_valid && out_ready && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({out_id, out_data} !== e) begin
        failures++; $display("FAIL single_result got id=%0d d=%h exp id=%0d d=%h", out_id, out_data, e[8:7], e[6:0]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt !== 16'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done got cnt=%0d v=%b busy=%b exp cnt=1 v=0 busy=0", done_cnt, out_valid, busy);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL single_drain got pending=%0d exp=0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_round_robin();
    int          order[5]  = '{0, 1, 2, 3, 0};
    logic [6:0]  vals[5]   = '{7'h54, 7'h57, 7'h56, 7'h51, 7'h54};
    int          gnum = 0, last_c = 0;
    logic [3:0]  oh;
    logic [8:0]  e;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_data = {11'h004, 11'h003, 11'h002, 11'h001}; req_valid = 4'hF;
      end
      if (c == 10) req_valid = '0;
      #1;
      if (req_ready !== 4'b0) begin
        oh = 4'b0001 << ((gnum < 5) ? order[gnum] : 0);
        checks++;
        if (gnum >= 5 || req_ready !== oh) begin
          failures++; $display("FAIL rr_grant#%0d got=%b exp=%b", gnum, req_ready, oh);
        end
        if (gnum > 0) begin
          checks++;
          if (c - last_c != 2) begin
            failures++; $display("FAIL rr_spacing got=%0d exp=2", c - last_c);
          end
        end
        if (gnum < 5) sb_q.push_back({2'(order[gnum]), vals[gnum]});
        last_c = c; gnum++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL rr_result got unexpected id=%0d d=%h exp none", out_id, out_data);
        end else begin
          e = sb_q.pop_front();
          if ({out_id, out_data} !== e) begin
            failures++; $display("FAIL rr_result got id=%0d d=%h exp id=%0d d=%h", out_id, out_data, e[8:7], e[6:0]);
          end
        end
      end
    end
    checks++;
    if (gnum != 5 || sb_q.size() != 0) begin
      failures++; $display("FAIL rr_count got grants=%0d pending=%0d exp grants=5 pending=0", gnum, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_multicycle();
    @(negedge clk); req_valid3 = 4'b0001; req_data3[10:0] = 11'h1A5; #1;
    checks++;
    if (req_ready3 !== 4'b0001) begin
      failures++; $display("FAIL mc_grant got=%b exp=0001", req_ready3);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); req_valid3 = '0; req_data3 = '0;
      if (c == 3) stub_en3 = 1'b1;
      #1;
      checks++;
      if (out_valid3 !== 1'b0 || conv_x3 !== 11'h1A5) begin
        failures++; $display("FAIL mc_window%0d got v=%b x=%h exp v=0 x=1a5", c, out_valid3, conv_x3);
      end
    end
    @(negedge clk); stub_en3 = 1'b0; #1;
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 7'h70 || out_id3 !== 2'd0 || conv_x3 !== 11'h1A5) begin
      failures++; $display("FAIL mc_result got v=%b d=%h id=%0d x=%h exp v=1 d=70 id=0 x=1a5",
                           out_valid3, out_data3, out_id3, conv_x3);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid3 !== 1'b0 || done_cnt3 !== 16'd1) begin
      failures++; $display("FAIL mc_done got v=%b cnt=%0d exp v=0 cnt=1", out_valid3, done_cnt3);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    do_reset();
    out_ready = 1'b0;
    @(negedge clk); req_valid = 4'b0010; req_data = {11'h0, 11'h044, 11'h033, 11'h0}; #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_grant got=%b exp=0010", req_ready);
    end
    sb_q.push_back({2'd1, 7'h66});
    @(negedge clk); req_valid = 4'b0110; #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL bp_wait_ready got=%b exp=0000", req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h66 || out_id !== 2'd1 || req_ready !== 4'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_stall%0d got v=%b d=%h id=%0d rdy=%b busy=%b exp v=1 d=66 id=1 rdy=0000 busy=1",
                             c, out_valid, out_data, out_id, req_ready, busy);
      end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL bp_regrant got=%b exp=0100", req_ready);
    end
    sb_q.push_back({2'd2, 7'h11});
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(negedge clk); req_valid = '0; #1;
      end
      if (c == 1) begin
        checks++;
        if (conv_x !== 11'h044 || out_valid !== 1'b0 || busy !== 1'b1 || done_cnt !== 16'd1) begin
          failures++; $display("FAIL bp_after got x=%h v=%b busy=%b cnt=%0d exp x=044 v=0 busy=1 cnt=1",
                               conv_x, out_valid, busy, done_cnt);
        end
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({out_id, out_data} !== e) begin
          failures++; $display("FAIL bp_result got id=%0d d=%h exp id=%0d d=%h", out_id, out_data, e[8:7], e[6:0]);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL bp_drain got pending=%0d exp=0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_reset_midflight();
    logic [8:0] e;
    @(negedge clk); req_valid = 4'b1000; req_data = {11'h0AA, 11'h0, 11'h0, 11'h0BB}; #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL rst_setup_grant got=%b exp=1000", req_ready);
    end
    @(negedge clk); req_valid = 4'b1001; #2; rst_n = 1'b0; #1;
    checks++;
    if ({req_ready, conv_x, out_valid, out_data, out_id, busy, done_cnt} !== 42'd0) begin
      failures++; $display("FAIL rst_async got rdy=%b x=%h v=%b d=%h id=%0d busy=%b cnt=%h exp all zero",
                           req_ready, conv_x, out_valid, out_data, out_id, busy, done_cnt);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0001 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_first_grant got rdy=%b v=%b exp rdy=0001 v=0", req_ready, out_valid);
    end
    sb_q.push_back({2'd0, 7'h6E});
    @(negedge clk); req_valid = '0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_no_glitch got out_valid=%b exp=0", out_valid);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({out_id, out_data} !== e) begin
          failures++; $display("FAIL rst_result got id=%0d d=%h exp id=%0d d=%h", out_id, out_data, e[8:7], e[6:0]);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL rst_drain got pending=%0d exp=0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_saturation();
    int          hs = 0;
    logic [16:0] ecnt;
    logic [8:0]  e;
    @(negedge clk); force dut.done_cnt_q = 16'hFFFC;
    @(negedge clk); release dut.done_cnt_q;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid = 4'b0010; req_data = {11'h0, 11'h0, 11'h12A, 11'h0};
      end
      if (c == 10) req_valid = '0;
      #1;
      ecnt = 17'h0FFFC + 17'(hs);
      if (ecnt > 17'h0FFFF) ecnt = 17'h0FFFF;
      checks++;
      if (done_cnt !== ecnt[15:0]) begin
        failures++; $display("FAIL sat_cnt c=%0d got=%h exp=%h", c, done_cnt, ecnt[15:0]);
      end
      if (req_ready !== 4'b0) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          failures++; $display("FAIL sat_grant got=%b exp=0010", req_ready);
        end
        sb_q.push_back({2'd1, model(11'h12A)});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL sat_result got unexpected id=%0d d=%h exp none", out_id, out_data);
        end else begin
          e = sb_q.pop_front();
          if ({out_id, out_data} !== e) begin
            failures++; $display("FAIL sat_result got id=%0d d=%h exp id=%0d d=%h", out_id, out_data, e[8:7], e[6:0]);
          end
        end
        hs++;
      end
    end
    checks++;
    if (hs != 5 || sb_q.size() != 0) begin
      failures++; $display("FAIL sat_count got handshakes=%0d pending=%0d exp 5 and 0", hs, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_multicycle();
    test_backpressure();
    test_reset_midflight();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

module int_dummy_guard;
endmodule

// File: doc/int2float_sched.md
Name: int2float_sched

Overview:
- Shares one combinational int2float converter (11-bit integer in, 7-bit float code out) among N requesters.
- Round-robin arbitration across requesters.
- Holds the operand stable across a programmable multicycle conversion window, registers the result, and returns it with the requester ID over a valid/ready interface.
- Sits between the IMC operand producers and the single converter instance; the converter itself stays outside this block.

Parameters:
- N, 4: number of requesters; legal 2..16.
- CONV_LAT, 1: cycles the converter output needs before it is sampled; legal 1..15.
- IDW, $clog2(N): width of the requester-ID field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N  per-requester request valid.
- req_data  input  N*11  packed operands; requester i uses bits [11*i+10 : 11*i].
- req_ready  output  N  one-hot acceptance strobe; at most one bit set.
- conv_x  output  11  operand to the shared converter.
- conv_y  input  7  converter result.
- out_valid  output  1  result available.
- out_data  output  7  registered conversion result.
- out_id  output  IDW  index of the requester that owns out_data.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state is not IDLE.
- done_cnt  output  16  count of completed output handshakes; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, rst_n=0) sets the following, and holds them while rst_n is low:
  - state=IDLE; conv_x=0; out_valid=0; out_data=0; out_id=0; done_cnt=0; req_ready=0.
  - RR pointer=N-1, so requester 0 has first priority.
- States: IDLE, WAIT, DONE.
- Arbitration runs in IDLE, and in DONE only when out_valid & out_ready.
  - Grant goes to the first i with req_valid[i]=1, searching from ptr+1 upward mod N.
  - req_ready[g] is asserted combinationally in that cycle.
  - Accept edge: operand register (conv_x) <= req_data[g]; id register <= g; ptr <= g; cnt <= CONV_LAT-1; state <= WAIT.
- In WAIT, conv_x is held constant.
  - cnt>0: cnt decrements.
  - cnt==0: out_data <= conv_y; out_id <= id; out_valid <= 1; state <= DONE.
- Latency: accept at edge E0, out_valid high from edge E0+CONV_LAT.
- In DONE, out_data and out_id are held stable while out_valid & !out_ready.
  - On handshake: done_cnt increments (saturating).
  - If a grant occurs in the same cycle, go to WAIT with the new operand and drop out_valid; otherwise go to IDLE and drop out_valid.
- Peak throughput: one result per CONV_LAT+1 cycles.
- req_ready is never asserted in WAIT, or in DONE without out_ready.
- A requester that drops req_valid before being granted is simply skipped. No state is kept per requester.
- The RR pointer changes only on grant. A lone active requester is granted back-to-back.
- conv_x keeps its last operand in IDLE; it does not return to 0.
- Reset mid-operation: an in-flight conversion and a pending result are discarded. No req_ready or out_valid glitch follows deassertion.
- Illegal parameter values are caught by an elaboration-time assertion.

Decomposition:
- Shared package int2float_pkg holds:
  - INT_W=11 and FLT_W=7;
  - the state enum (IDLE/WAIT/DONE);
  - the done_cnt width constant.
- One sub-module, rr_arbiter: parameter N; inputs req, ptr, en; outputs grant_onehot, grant_idx, any.
- The top level instantiates rr_arbiter, the FSM/counter, and the output register.

Test Plan:
- The bench converter stub is conv_y = conv_x[6:0] ^ 7'h55. Unless a line says otherwise: N=4, CONV_LAT=1, out_ready=1.
1. Single request: req_valid=4'b0001, req_data[0]=11'h07F -> req_ready=0001 at edge E0; out_valid at E1 with out_data=7'h2A, out_id=0; done_cnt=1.
2. All four valid and held with operands 11'h001..11'h004 -> grants in order 0,1,2,3,0; out_data sequence 54,57,56,51 (hex); one result every 2 cycles.
3. CONV_LAT=3, conv_y changed only in cycle E0+2 -> sampled value reflects conv_x at E0+3; conv_x stable for the whole window.
4. out_ready held low 5 cycles in DONE -> out_data/out_id stable, req_ready=0, busy=1; release -> handshake and an immediate new grant in the same cycle.
5. rst_n pulsed low mid-WAIT (asynchronous, between edges) -> outputs are immediately at reset values; after release, requester 0 is granted first even if requester 3 was in flight.
6. Preload done_cnt near 16'hFFFF by running 65540 handshakes -> done_cnt holds 16'hFFFF; no wrap to 0.
